serial_adder: RTL and testbench

- Bit-serial N-bit adder with a start/done handshake. It is the addition counterpart to the team's subtractor cells.
- Operands are captured on `start`. One full-adder slice per clock is applied LSB-first, with a registered carry.
- A one-cycle `done` strobe is raised with the final sum and carry-out.
- Used where area matters more than latency, for example datapath accumulation in small control blocks.

---
 rtl/serial_adder.sv | 91 +++++++++
 tb/tb_serial_adder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, start/done handshake
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] s_next;

  assign s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign s_next = {s_bit, s_sh[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // The DONE cycle's closing edge is the return to IDLE, so a pending
        // start is taken there to sustain one operation per WIDTH+1 cycles.
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            s_sh  <= '0;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_next;
          carry <= c_next;
          if (cnt == LAST) begin
            cnt   <= '0;
            sum   <= s_next;
            cout  <= c_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_checks = 0;
  int n_fails  = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts one op at the next edge (E0), scrambles inputs during SHIFT, and
  // checks busy span, done position, sum holding, and the final result.
  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [7:0] es, input logic ec);
    int busy_cnt = 0, done_cnt = 0, done_at = -1, both = 0, early = 0;
    logic [7:0] prev_sum;
    @(negedge clk);
    prev_sum = sum;
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = ~va; b = va ^ vb; cin = ~vc;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; if (done_at < 0) done_at = j; end
      if (busy && done) both++;
      if (j < 8 && sum !== prev_sum) early++;
      if (j == 8) begin
        check({tag, " sum"}, sum, es);
        check({tag, " cout"}, cout, ec);
      end
    end
    check({tag, " busy cycles"}, busy_cnt, 8);
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " done latency"}, done_at, 8);
    check({tag, " busy&done"}, both, 0);
    check({tag, " sum held"}, early, 0);
  endtask

  initial begin
    int done_cnt, d1, d2, both;

    // async reset without any clock edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add 3C+05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
    run_op("add FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("add FF+FF+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // async reset mid-cycle from a nonzero sum
    #3 rst = 1'b1;
    #1;
    check("midcycle rst sum", sum, 0);
    check("midcycle rst cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;

    // start pulsed mid-SHIFT is ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (j == 3) begin a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1; end
      if (j == 4) begin start = 1'b0; a = 8'h01; end
      if (done) done_cnt++;
      if (j == 8) begin
        check("ignored start sum", sum, 8'h30);
        check("ignored start cout", cout, 0);
      end
    end
    check("ignored start done count", done_cnt, 1);

    // reset mid-operation aborts without done
    @(negedge clk);
    a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort sum", sum, 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("abort stays idle", done_cnt, 0);
    run_op("after abort 7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

    // back-to-back with start held high
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 a = 8'h80; b = 8'h80;
    d1 = -1; d2 = -1; both = 0;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (j == 9) start = 1'b0;
      if (done && busy) both++;
      if (done) begin
        if (d1 < 0) d1 = j;
        else if (d2 < 0) d2 = j;
      end
      if (j == 8) begin
        check("b2b first sum", sum, 8'h02);
        check("b2b first cout", cout, 0);
      end
      if (j == 16) check("b2b sum held", sum, 8'h02);
      if (j == 17) begin
        check("b2b second sum", sum, 8'h00);
        check("b2b second cout", cout, 1);
      end
    end
    check("b2b first done", d1, 8);
    check("b2b done spacing", d2 - d1, 9);
    check("b2b busy&done", both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
